mips_fetch_unit: RTL and testbench
==================================

# mips_fetch_unit

Instruction fetch sequencer for the single-issue MIPS core. Owns the PC, fetches 32-bit words from instruction memory over a req/ack handshake, and presents the opcode field to the control unit. It consumes the control unit's Jump/Branch outputs plus the ALU zero flag to select the next PC. It is the producing end of the control unit's opcode interface.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TIMEOUT, 16, max cycles to wait for imem_ack (used only with FETCH_TIMEOUT_EN)

- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  fetch address (= PC)
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word
- stall_i  in  1  downstream hold; freezes ISSUE
- jump_i  in  1  control unit Jump
- branch_i  in  1  control unit Branch
- zero_i  in  1  ALU zero flag
- opcode_o  out  6  IR[31:26] to control unit
- instr_o  out  32  full instruction register
- instr_valid_o  out  1  IR holds an instruction being issued
- pc_o  out  32  PC of issued instruction
- retire_cnt_o  out  32  count of instructions that left ISSUE
- fetch_err_o  out  1  sticky timeout error (0 when macro absent)

## Operation
- States: FETCH, ISSUE, HALT (HALT reachable only with FETCH_TIMEOUT_EN).
- FETCH: imem_req=1, imem_addr=PC. On imem_ack: IR<=imem_rdata, go ISSUE. imem_rdata ignored when imem_ack=0.
- ISSUE: instr_valid_o=1, opcode_o=IR[31:26]. jump_i/branch_i/zero_i sampled here only.
  - stall_i=1: hold state, PC, IR; no retire.
  - stall_i=0: PC<=next_pc, retire_cnt_o+=1, go FETCH.
- next_pc priority: jump_i -> {pc4[31:28], IR[25:0], 2'b00}; else branch_i&zero_i -> pc4 + (sext(IR[15:0])<<2); else pc4. pc4=PC+4. All arithmetic modulo 2^32, wrap at 32'hFFFF_FFFC to 0 silently.
- jump_i and branch_i both 1: jump wins.
- retire_cnt_o wraps 32'hFFFF_FFFF -> 0.
- HALT: imem_req=0, instr_valid_o=0, fetch_err_o=1; left only by reset.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, IR=0, opcode_o=6'b0, instr_valid_o=0, imem_req=0 during reset, retire_cnt_o=0, fetch_err_o=0.
- First cycle after rst_n rises: imem_req=1, imem_addr=RESET_PC.
- imem_ack may arrive in the first req cycle (zero-wait memory); minimum 2 cycles per instruction (1 FETCH + 1 ISSUE).
- imem_req and imem_addr stable from assertion until the ack cycle; req drops the cycle after ack.
- Outputs registered except opcode_o/instr_o (direct from IR) and imem_addr (direct from PC).
- Reset mid-fetch: req drops asynchronously; a later ack with no req is ignored.

## Configuration
- FETCH_TIMEOUT_EN defined: a wait counter clears on entering FETCH and increments each FETCH cycle without ack; on reaching TIMEOUT without ack -> HALT, fetch_err_o=1 sticky. Ack in the TIMEOUT-th cycle is accepted normally.
- Undefined: no counter, no HALT state; FETCH waits indefinitely; fetch_err_o tied 0.

## Structure
- mips_pkg: opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_ADDI=6'b001000, OP_J=6'b000010; fetch state enum; XLEN=32.
- One sub-module: mips_next_pc (combinational next-PC mux: PC, IR, jump, branch, zero -> next_pc).

## Test plan
- Reset, zero-wait memory returning 32'h8C22_0004 (lw) at 0 -> opcode_o=6'b100011 in cycle 2, next imem_addr=0x4, retire_cnt_o=1.
- IR=32'h0800_0010 (j), jump_i=1 at PC 0x0 -> next imem_addr=0x0000_0040.
- IR=32'h1000_FFFF (beq), branch_i=1, zero_i=1 at PC 0x100 -> imem_addr=0x100; with zero_i=0 -> 0x104.
- stall_i=1 for 3 ISSUE cycles -> IR/PC/opcode_o held, retire_cnt_o unchanged, imem_req=0; releases to FETCH on cycle 4.
- imem_ack delayed 5 cycles -> imem_req/imem_addr stable all 5; with FETCH_TIMEOUT_EN and TIMEOUT=4, no ack -> fetch_err_o=1 after 4 cycles, req=0 until reset.
- rst_n low during FETCH wait -> imem_req=0 immediately, PC=RESET_PC; late ack ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch path: opcode encodings,
// datapath width and the fetch sequencer state encoding.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // HALT is only ever entered when the fetch timeout is built in.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC select: jump beats taken branch beats sequential PC+4.
// All sums wrap modulo 2^32.
module mips_next_pc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] ir,
  input  logic            jump,
  input  logic            branch,
  input  logic            zero,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] branch_target;

  assign pc4           = pc + 32'd4;
  assign jump_target   = {pc4[31:28], ir[25:0], 2'b00};
  assign branch_target = pc4 + {{14{ir[15]}}, ir[15:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches over a req/ack handshake and
// issues the IR to the control unit. Define FETCH_TIMEOUT_EN for the ack timeout/HALT.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall_i,
  input  logic            jump_i,
  input  logic            branch_i,
  input  logic            zero_i,
  output logic [5:0]      opcode_o,
  output logic [XLEN-1:0] instr_o,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] retire_cnt_o,
  output logic            fetch_err_o
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, ir, next_pc, retire_cnt;
  logic            req_q, valid_q;
  logic            take_ack, leave_issue, timeout_hit;

  // An ack only counts while our request is actually on the bus.
  assign take_ack    = (state == ST_FETCH) && req_q && imem_ack;
  assign leave_issue = (state == ST_ISSUE) && !stall_i;

  mips_next_pc u_next_pc (
    .pc      (pc),
    .ir      (ir),
    .jump    (jump_i),
    .branch  (branch_i),
    .zero    (zero_i),
    .next_pc (next_pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;
  logic          err_q;

  assign timeout_hit = (state == ST_FETCH) && req_q && !imem_ack && (wait_cnt == WAIT_LAST);

  // Counter only runs while a request waits; anything else clears it for the next fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state == ST_FETCH) && req_q && !imem_ack) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fetch_err_o = err_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: begin
        if (take_ack) begin
          state_next = ST_ISSUE;
        end else if (timeout_hit) begin
          state_next = ST_HALT;
        end
      end
      ST_ISSUE: begin
        if (!stall_i) begin
          state_next = ST_FETCH;
        end
      end
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_FETCH;
    endcase
  end

  // req/valid are registered from the next state so they track the state one-for-one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      ir         <= '0;
      retire_cnt <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      req_q   <= (state_next == ST_FETCH);
      valid_q <= (state_next == ST_ISSUE);
      if (take_ack) begin
        ir <= imem_rdata;
      end
      if (leave_issue) begin
        pc         <= next_pc;
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc;
  assign opcode_o      = ir[31:26];
  assign instr_o       = ir;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc;
  assign retire_cnt_o  = retire_cnt;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed table-driven bench for mips_fetch_unit plus reset-mid-fetch and
// ack-timeout (or indefinite wait, without FETCH_TIMEOUT_EN) sequences.
module tb_mips_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall_i, jump_i, branch_i, zero_i;
  logic [5:0]  opcode_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic [31:0] retire_cnt_o;
  logic        fetch_err_o;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mips_fetch_unit #(
    .RESET_PC (32'h0000_0000)
`ifdef FETCH_TIMEOUT_EN
    ,
    .TIMEOUT  (4)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall_i       (stall_i),
    .jump_i        (jump_i),
    .branch_i      (branch_i),
    .zero_i        (zero_i),
    .opcode_o      (opcode_o),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .pc_o          (pc_o),
    .retire_cnt_o  (retire_cnt_o),
    .fetch_err_o   (fetch_err_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic        jump;
    logic        branch;
    logic        zero;
    int          ack_delay;
    int          stall_cycles;
    logic [5:0]  exp_op;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] pc_model;
    logic [31:0] retire_model;

    vecs[0]  = '{32'h8C22_0004, 1'b0, 1'b0, 1'b0, 0, 0, OP_LW,    32'h0000_0004};
    vecs[1]  = '{32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 2, 0, OP_BEQ,   32'h0000_0008};
    vecs[2]  = '{32'h1000_0003, 1'b0, 1'b1, 1'b1, 0, 3, OP_BEQ,   32'h0000_0018};
    vecs[3]  = '{32'h0800_0040, 1'b1, 1'b0, 1'b0, 5, 0, OP_J,     32'h0000_0100};
    vecs[4]  = '{32'h1000_FFFF, 1'b0, 1'b1, 1'b1, 1, 0, OP_BEQ,   32'h0000_0100};
    vecs[5]  = '{32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 0, 1, OP_BEQ,   32'h0000_0104};
    vecs[6]  = '{32'h0800_0010, 1'b1, 1'b1, 1'b1, 0, 0, OP_J,     32'h0000_0040};
    vecs[7]  = '{32'h2001_0005, 1'b0, 1'b0, 1'b0, 3, 0, OP_ADDI,  32'h0000_0044};
    vecs[8]  = '{32'hAC22_0008, 1'b0, 1'b1, 1'b0, 0, 2, OP_SW,    32'h0000_0048};
    vecs[9]  = '{32'h0022_1820, 1'b0, 1'b0, 1'b1, 0, 0, OP_RTYPE, 32'h0000_004C};
    vecs[10] = '{32'h1000_FFEB, 1'b0, 1'b1, 1'b1, 0, 0, OP_BEQ,   32'hFFFF_FFFC};
    vecs[11] = '{32'h8C22_0004, 1'b0, 1'b0, 1'b0, 1, 0, OP_LW,    32'h0000_0000};
    vecs[12] = '{32'h2001_0005, 1'b0, 1'b0, 1'b0, 0, 0, OP_ADDI,  32'h0000_0004};

    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall_i    = 1'b0;
    jump_i     = 1'b0;
    branch_i   = 1'b0;
    zero_i     = 1'b0;
    repeat (2) tick();

    check("rst req",    {31'b0, imem_req},      32'h0);
    check("rst addr",   imem_addr,              32'h0);
    check("rst valid",  {31'b0, instr_valid_o}, 32'h0);
    check("rst opcode", {26'b0, opcode_o},      32'h0);
    check("rst instr",  instr_o,                32'h0);
    check("rst retire", retire_cnt_o,           32'h0);
    check("rst err",    {31'b0, fetch_err_o},   32'h0);

    rst_n = 1'b1;
    tick();
    check("post-rst req",  {31'b0, imem_req}, 32'h1);
    check("post-rst addr", imem_addr,         32'h0);

    pc_model     = 32'h0;
    retire_model = 32'h0;

    for (int i = 0; i < 13; i++) begin
      for (int d = 0; d < vecs[i].ack_delay; d++) begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        tick();
        check($sformatf("v%0d wait%0d req", i, d), {31'b0, imem_req}, 32'h1);
        check($sformatf("v%0d wait%0d addr", i, d), imem_addr, pc_model);
      end

      imem_ack   = 1'b1;
      imem_rdata = vecs[i].instr;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;

      check($sformatf("v%0d valid", i),  {31'b0, instr_valid_o}, 32'h1);
      check($sformatf("v%0d opcode", i), {26'b0, opcode_o},      {26'b0, vecs[i].exp_op});
      check($sformatf("v%0d instr", i),  instr_o,                vecs[i].instr);
      check($sformatf("v%0d pc", i),     pc_o,                   pc_model);
      check($sformatf("v%0d issue req", i), {31'b0, imem_req},   32'h0);
      check($sformatf("v%0d issue retire", i), retire_cnt_o,     retire_model);

      for (int s = 0; s < vecs[i].stall_cycles; s++) begin
        stall_i  = 1'b1;
        jump_i   = ~vecs[i].jump;
        branch_i = 1'b1;
        zero_i   = 1'b1;
        tick();
        check($sformatf("v%0d stall%0d valid", i, s),  {31'b0, instr_valid_o}, 32'h1);
        check($sformatf("v%0d stall%0d opcode", i, s), {26'b0, opcode_o}, {26'b0, vecs[i].exp_op});
        check($sformatf("v%0d stall%0d pc", i, s),     pc_o,         pc_model);
        check($sformatf("v%0d stall%0d retire", i, s), retire_cnt_o, retire_model);
        check($sformatf("v%0d stall%0d req", i, s),    {31'b0, imem_req}, 32'h0);
      end

      stall_i  = 1'b0;
      jump_i   = vecs[i].jump;
      branch_i = vecs[i].branch;
      zero_i   = vecs[i].zero;
      tick();
      jump_i   = 1'b0;
      branch_i = 1'b0;
      zero_i   = 1'b0;
      retire_model = retire_model + 32'd1;
      pc_model     = vecs[i].exp_next;

      check($sformatf("v%0d next req", i),    {31'b0, imem_req},      32'h1);
      check($sformatf("v%0d next addr", i),   imem_addr,              pc_model);
      check($sformatf("v%0d next valid", i),  {31'b0, instr_valid_o}, 32'h0);
      check($sformatf("v%0d next retire", i), retire_cnt_o,           retire_model);
    end

    // Reset asserted while a fetch is outstanding, with a stray ack around release
    tick();
    check("midrst pre req",  {31'b0, imem_req}, 32'h1);
    check("midrst pre addr", imem_addr,         32'h4);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst_n      = 1'b0;
    #1;
    check("midrst req",    {31'b0, imem_req},      32'h0);
    check("midrst addr",   imem_addr,              32'h0);
    check("midrst retire", retire_cnt_o,           32'h0);
    check("midrst valid",  {31'b0, instr_valid_o}, 32'h0);
    check("midrst instr",  instr_o,                32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("late ack valid", {31'b0, instr_valid_o}, 32'h0);
    check("late ack instr", instr_o,                32'h0);
    check("late ack req",   {31'b0, imem_req},      32'h1);
    check("late ack addr",  imem_addr,              32'h0);
    imem_ack = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    repeat (3) tick();
    check("to cyc4 err", {31'b0, fetch_err_o}, 32'h0);
    check("to cyc4 req", {31'b0, imem_req},    32'h1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h8C22_0004;
    tick();
    imem_ack = 1'b0;
    check("to last ack valid", {31'b0, instr_valid_o}, 32'h1);
    check("to last ack err",   {31'b0, fetch_err_o},   32'h0);
    tick();
    check("to refetch addr", imem_addr,         32'h4);
    check("to refetch req",  {31'b0, imem_req}, 32'h1);
    repeat (4) tick();
    check("halt err",   {31'b0, fetch_err_o},   32'h1);
    check("halt req",   {31'b0, imem_req},      32'h0);
    check("halt valid", {31'b0, instr_valid_o}, 32'h0);
    imem_ack = 1'b1;
    repeat (3) tick();
    imem_ack = 1'b0;
    check("halt sticky err",   {31'b0, fetch_err_o},   32'h1);
    check("halt sticky req",   {31'b0, imem_req},      32'h0);
    check("halt sticky valid", {31'b0, instr_valid_o}, 32'h0);
`else
    repeat (20) tick();
    check("longwait req",   {31'b0, imem_req},      32'h1);
    check("longwait addr",  imem_addr,              32'h0);
    check("longwait err",   {31'b0, fetch_err_o},   32'h0);
    check("longwait valid", {31'b0, instr_valid_o}, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h8C22_0004;
    tick();
    imem_ack = 1'b0;
    check("longwait ack valid",  {31'b0, instr_valid_o}, 32'h1);
    check("longwait ack opcode", {26'b0, opcode_o},      {26'b0, OP_LW});
    check("longwait ack err",    {31'b0, fetch_err_o},   32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
